// File: rtl/request_serializer_pkg.sv
// Shared state encoding and helpers for the request serializer.
// Drains a latched request vector one code per handshake.
package request_serializer_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SERVE = 1'b1;

    typedef enum logic {
        S_IDLE  = ST_IDLE,
        S_SERVE = ST_SERVE
    } state_e;

    // Width of a code that can name any of n request bits.
    function automatic int code_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/request_serializer_priority_encoder.sv
// Picks the highest-indexed set bit: code c names bit INPUTS-1-c.
// in_mask is the input with that bit cleared; out is 0 when in is 0.
module priority_encoder
    import request_serializer_pkg::*;
#(
    parameter int INPUTS    = 3,
    parameter int OUT_WIDTH = code_width(INPUTS)
) (
    input  logic [INPUTS-1:0]    in,
    output logic [OUT_WIDTH-1:0] out,
    output logic [INPUTS-1:0]    in_mask
);

    logic found;

    always_comb begin
        out     = '0;
        in_mask = in;
        found   = 1'b0;
        for (int i = INPUTS - 1; i >= 0; i--) begin
            if (in[i] && !found) begin
                found      = 1'b1;
                out        = OUT_WIDTH'(INPUTS - 1 - i);
                in_mask[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/request_serializer.sv
// Latches a request vector and emits one priority code per handshake,
// highest-indexed bit first, pulsing batch_done after the final code.
module request_serializer
    import request_serializer_pkg::*;
#(
    parameter int INPUTS    = 3,
    parameter int OUT_WIDTH = code_width(INPUTS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [INPUTS-1:0]    req_in,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 flush,
    output logic [OUT_WIDTH-1:0] code_out,
    output logic                 code_valid,
    input  logic                 code_ready,
    output logic [INPUTS-1:0]    pending,
    output logic                 batch_done
);

    state_e              state_q, state_d;
    logic [INPUTS-1:0]   pending_q, pending_d;
    logic                batch_done_q, batch_done_d;
    logic [INPUTS-1:0]   pending_masked;
    logic [OUT_WIDTH-1:0] enc_code;

    priority_encoder #(
        .INPUTS    (INPUTS),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_enc (
        .in      (pending_q),
        .out     (enc_code),
        .in_mask (pending_masked)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pending_q    <= '0;
            batch_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            batch_done_q <= batch_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        batch_done_d = 1'b0;
        req_ready    = 1'b0;
        code_valid   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                // An all-zero vector is consumed but starts no batch.
                if (req_valid && (req_in != '0)) begin
                    pending_d = req_in;
                    state_d   = S_SERVE;
                end
            end
            S_SERVE: begin
                code_valid = 1'b1;
                // Flush wins over a same-cycle handshake: that code is not consumed.
                if (flush) begin
                    pending_d = '0;
                    state_d   = S_IDLE;
                end else if (code_ready) begin
                    pending_d = pending_masked;
                    if (pending_masked == '0) begin
                        state_d      = S_IDLE;
                        batch_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                pending_d = '0;
            end
        endcase
    end

    assign code_out   = enc_code;
    assign pending    = pending_q;
    assign batch_done = batch_done_q;

endmodule

// File: tb/tb_request_serializer.sv
// Directed bench for request_serializer with INPUTS=3 (bit2->code0, bit1->code1, bit0->code2).
module tb_request_serializer;

    localparam int INPUTS    = 3;
    localparam int OUT_WIDTH = 2;

    logic                 clk;
    logic                 rst_n;
    logic [INPUTS-1:0]    req_in;
    logic                 req_valid;
    logic                 req_ready;
    logic                 flush;
    logic [OUT_WIDTH-1:0] code_out;
    logic                 code_valid;
    logic                 code_ready;
    logic [INPUTS-1:0]    pending;
    logic                 batch_done;

    int checks = 0;
    int errors = 0;

    request_serializer #(.INPUTS(INPUTS), .OUT_WIDTH(OUT_WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_in     (req_in),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .flush      (flush),
        .code_out   (code_out),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .pending    (pending),
        .batch_done (batch_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and land on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_idle(input string tag, input logic exp_done);
        chk({tag, " req_ready"},  32'(req_ready),  32'd1);
        chk({tag, " code_valid"}, 32'(code_valid), 32'd0);
        chk({tag, " pending"},    32'(pending),    32'd0);
        chk({tag, " batch_done"}, 32'(batch_done), 32'(exp_done));
        chk({tag, " code_out"},   32'(code_out),   32'd0);
    endtask

    task automatic chk_serve(input string tag, input logic [1:0] exp_code, input logic [2:0] exp_pend);
        chk({tag, " code_valid"}, 32'(code_valid), 32'd1);
        chk({tag, " req_ready"},  32'(req_ready),  32'd0);
        chk({tag, " code_out"},   32'(code_out),   32'(exp_code));
        chk({tag, " pending"},    32'(pending),    32'(exp_pend));
        chk({tag, " batch_done"}, 32'(batch_done), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_in     = '0;
        req_valid  = 1'b0;
        flush      = 1'b0;
        code_ready = 1'b0;

        // 1: reset
        step();
        step();
        chk_idle("t1 reset", 1'b0);

        // 2: 101 drained back-to-back
        rst_n = 1'b1; req_in = 3'b101; req_valid = 1'b1; code_ready = 1'b1;
        step();
        req_valid = 1'b0; req_in = '0;
        chk_serve("t2 c0", 2'd0, 3'b101);
        step();
        chk_serve("t2 c2", 2'd2, 3'b001);
        step();
        chk_idle("t2 done", 1'b1);
        step();
        chk_idle("t2 after", 1'b0);

        // 3: 111 with a 3-cycle stall; req_valid during SERVE ignored
        req_in = 3'b111; req_valid = 1'b1; code_ready = 1'b0;
        step();
        req_in = 3'b010;
        for (int i = 0; i < 3; i++) begin
            chk_serve("t3 stall", 2'd0, 3'b111);
            step();
        end
        chk_serve("t3 hold", 2'd0, 3'b111);
        req_valid = 1'b0; req_in = '0; code_ready = 1'b1;
        step();
        chk_serve("t3 c1", 2'd1, 3'b011);
        step();
        chk_serve("t3 c2", 2'd2, 3'b001);
        step();
        chk_idle("t3 done", 1'b1);

        // 4: zero vector consumed, no batch
        req_in = 3'b000; req_valid = 1'b1;
        step();
        chk_idle("t4 zero", 1'b0);
        req_valid = 1'b0;
        step();
        chk_idle("t4 zero2", 1'b0);

        // 5: flush after first code, with a simultaneous handshake
        req_in = 3'b111; req_valid = 1'b1; code_ready = 1'b1;
        step();
        req_valid = 1'b0; req_in = '0;
        chk_serve("t5 c0", 2'd0, 3'b111);
        step();
        chk_serve("t5 c1", 2'd1, 3'b011);
        flush = 1'b1;
        step();
        chk_idle("t5 flushed", 1'b0);
        step();
        chk_idle("t5 nodone", 1'b0);

        // flush in IDLE does not block acceptance
        req_in = 3'b100; req_valid = 1'b1; code_ready = 1'b0;
        step();
        flush = 1'b0; req_valid = 1'b0; req_in = '0;
        chk_serve("t5 idle flush", 2'd0, 3'b100);

        // 6: reset mid-SERVE, then a fresh 010 batch
        rst_n = 1'b0;
        step();
        chk_idle("t6 reset", 1'b0);
        rst_n = 1'b1; req_in = 3'b010; req_valid = 1'b1;
        step();
        req_valid = 1'b0; req_in = '0; code_ready = 1'b1;
        chk_serve("t6 c1", 2'd1, 3'b010);
        step();
        chk_idle("t6 done", 1'b1);
        step();
        chk_idle("t6 after", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
